// File: rtl/outport_uart_tx.sv
// Captures each new CPU outport value into a small FIFO and shifts it out as UART 8N1, LSB byte first.
// Latency: push 1 cycle after outport changes, start bit 1 cycle after the pop; one idle cycle between words.
// No backpressure on the CPU: a change arriving while full is dropped and sets the sticky overflow flag.
// Defining OUTPORT_TX_PARITY_EN adds an even-parity bit between the data bits and the stop bit.
module outport_uart_tx #(
    parameter int n            = 32,
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH        = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [n-1:0]             outport,
    output logic                     tx,
    output logic                     busy,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int NB = n / 8;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [TW-1:0] TMAX      = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(NB - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef OUTPORT_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          state;
    logic [n-1:0]    last;
    logic [n-1:0]    mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [n-1:0]    shreg;
    logic [BW-1:0]   byte_idx;
    logic [2:0]      bit_idx;
    logic [TW-1:0]   timer;

    logic            push;
    logic            pop;
    logic            full;
    logic            accept;
    logic            tend;
    logic [7:0]      cur;

    assign push   = (outport != last);
    assign full   = (fifo_count == FULL_CNT);
    assign pop    = (state == IDLE) && (fifo_count != '0);
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign accept = push && (!full || pop);
    assign tend   = (timer == TMAX);
    assign cur    = shreg[7:0];

    always_ff @(posedge clock) begin
        if (!reset && accept) begin
            mem[wptr] <= outport;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last       <= '0;
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            state      <= IDLE;
            tx         <= 1'b1;
            busy       <= 1'b0;
            shreg      <= '0;
            byte_idx   <= '0;
            bit_idx    <= '0;
            timer      <= '0;
        end else begin
            if (push) begin
                last <= outport;
            end
            if (accept) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
            case ({accept, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase

            if (state == IDLE) begin
                timer <= '0;
            end else begin
                timer <= tend ? '0 : timer + TW'(1);
            end

            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    if (pop) begin
                        shreg    <= mem[rptr];
                        byte_idx <= '0;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (tend) begin
                        bit_idx <= '0;
                        tx      <= cur[0];
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (tend) begin
                        if (bit_idx == 3'd7) begin
`ifdef OUTPORT_TX_PARITY_EN
                            tx    <= ^cur;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= cur[bit_idx + 3'd1];
                        end
                    end
                end
`ifdef OUTPORT_TX_PARITY_EN
                PARITY: begin
                    if (tend) begin
                        tx    <= 1'b1;
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (tend) begin
                        if (byte_idx != LAST_BYTE) begin
                            // Next byte of the same word follows with no idle gap.
                            byte_idx <= byte_idx + BW'(1);
                            shreg    <= shreg >> 8;
                            tx       <= 1'b0;
                            state    <= START;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_outport_uart_tx.sv
// Directed bench for outport_uart_tx: n=32, CLKS_PER_BIT=4, DEPTH=4.
// tx is recorded once per cycle and decoded by a reference UART receiver.
module tb_outport_uart_tx;

    localparam int CPB = 4;
`ifdef OUTPORT_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FL = FB * CPB;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] outport = '0;
    logic        tx;
    logic        busy;
    logic        overflow;
    logic [2:0]  fifo_count;

    int compared   = 0;
    int mismatched = 0;

    logic       rec = 1'b0;
    logic       txq[$];
    logic       bq[$];
    logic [7:0] rxb[$];
    int         ferr;

    outport_uart_tx #(.n(32), .CLKS_PER_BIT(CPB), .DEPTH(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .outport    (outport),
        .tx         (tx),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (rec) begin
            txq.push_back(tx);
            bq.push_back(busy);
        end
    endtask

    // Expected line level at position p (in bit periods) of a frame carrying b.
    function automatic logic frame_bit(input int p, input logic [7:0] b);
        if (p == 0) return 1'b0;
        if (p <= 8) return b[p-1];
        if (FB == 11 && p == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic decode();
        int i;
        logic [7:0] b;
        rxb.delete();
        ferr = 0;
        i = 0;
        while (i + FL <= txq.size()) begin
            if (txq[i] === 1'b0) begin
                for (int j = 0; j < 8; j++) b[j] = txq[i + (1 + j) * CPB + CPB / 2];
                if (txq[i + CPB / 2] !== 1'b0) ferr++;
                if (txq[i + (FB - 1) * CPB + CPB / 2] !== 1'b1) ferr++;
                if (FB == 11 && txq[i + 9 * CPB + CPB / 2] !== ^b) ferr++;
                rxb.push_back(b);
                i += FL;
            end else begin
                i++;
            end
        end
    endtask

    function automatic logic [31:0] word_at(input int w);
        return {rxb[4*w+3], rxb[4*w+2], rxb[4*w+1], rxb[4*w]};
    endfunction

    initial begin
        int bad;
        int ones;
        int first;
        logic [7:0] eb;
        int k;

        // Reset and quiet idle line
        reset = 1'b1;
        outport = '0;
        tick();
        tick();
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_count", fifo_count, 3'd0);
        check("rst_overflow", overflow, 1'b0);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0 || overflow !== 1'b0) bad++;
        end
        check("idle_quiet_cycles_bad", bad, 0);

        // Single word 0x000000A5: exact waveform
        txq.delete();
        bq.delete();
        rec = 1'b1;
        outport = 32'h0000_00A5;
        tick();
        check("a5_count_after_push", fifo_count, 3'd1);
        check("a5_idle_before_pop", tx, 1'b1);
        tick();
        check("a5_count_after_pop", fifo_count, 3'd0);
        check("a5_start_bit", tx, 1'b0);
        repeat (198) tick();
        bad = 0;
        for (int idx = 0; idx < 200; idx++) begin
            logic e;
            e = 1'b1;
            if (idx >= 1 && idx <= 4 * FL) begin
                k = idx - 1;
                eb = (k / FL == 0) ? 8'hA5 : 8'h00;
                e = frame_bit((k % FL) / CPB, eb);
            end
            if (txq[idx] !== e) bad++;
        end
        check("a5_waveform_bad_samples", bad, 0);
        ones = 0;
        first = -1;
        for (int idx = 0; idx < 200; idx++) begin
            if (bq[idx] === 1'b1) begin
                ones++;
                if (first < 0) first = idx;
            end
        end
        check("a5_busy_cycles", ones, 4 * FL);
        check("a5_busy_first", first, 1);
        decode();
        check("a5_bytes", rxb.size(), 4);
        check("a5_word", word_at(0), 32'h0000_00A5);

        // Back-to-back changes overfill the FIFO
        txq.delete();
        for (int v = 1; v <= 6; v++) begin
            outport = v;
            tick();
        end
        check("ovf_flag_set", overflow, 1'b1);
        check("ovf_count_full", fifo_count, 3'd4);
        repeat (900) tick();
        decode();
        check("ovf_bytes", rxb.size(), 20);
        check("ovf_framing_errs", ferr, 0);
        for (int w = 0; w < 5; w++) begin
            if (rxb.size() >= 4 * (w + 1)) check($sformatf("ovf_word%0d", w), word_at(w), w + 1);
        end
        check("ovf_drained", fifo_count, 3'd0);
        check("ovf_idle_busy", busy, 1'b0);

        // Constant value: exactly one word
        txq.delete();
        outport = 32'h1234_5678;
        repeat (500) tick();
        decode();
        check("hold_bytes", rxb.size(), 4);
        if (rxb.size() == 4) begin
            check("hold_b0", rxb[0], 8'h78);
            check("hold_b1", rxb[1], 8'h56);
            check("hold_b2", rxb[2], 8'h34);
            check("hold_b3", rxb[3], 8'h12);
        end
        check("ovf_sticky", overflow, 1'b1);

        // Reset in the middle of the second byte's data bits
        rec = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("ovf_cleared", overflow, 1'b0);
        outport = 32'hAABB_CCDD;
        tick();
        tick();
        check("mid_start_bit", tx, 1'b0);
        outport = 32'h1122_3344;
        repeat (FL + CPB + 10) tick();
        check("mid_busy", busy, 1'b1);
        check("mid_queued", fifo_count, 3'd1);
        reset = 1'b1;
        outport = '0;
        tick();
        check("abort_tx", tx, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_count", fifo_count, 3'd0);
        reset = 1'b0;
        txq.delete();
        bq.delete();
        rec = 1'b1;
        repeat (300) tick();
        bad = 0;
        for (int idx = 0; idx < 300; idx++) begin
            if (txq[idx] !== 1'b1 || bq[idx] !== 1'b0) bad++;
        end
        check("abort_silent_bad", bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
